// File: rtl/trans_ctrl.sv
// trans_ctrl: reads a size x size matrix of packed rows into a local buffer, then writes its
// transpose back. Define TRANS_ZERO_PAD_EN to always write N rows, zero-filling rows >= size.
module trans_ctrl #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned N      = 5,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          size,
  input  logic [ADDR_W-1:0]   src_base,
  input  logic [ADDR_W-1:0]   dst_base,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [N*ELEM_W-1:0] mem_rd_data,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [N*ELEM_W-1:0] mem_wr_data
);

  localparam int unsigned RowW    = N * ELEM_W;
  localparam logic [2:0]  MaxSize = 3'(N);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [2:0]        rd_cnt_q, rd_cnt_d;
  logic [2:0]        cap_cnt_q, cap_cnt_d;
  logic [2:0]        wr_cnt_q, wr_cnt_d;
  logic              cap_en_q, cap_en_d;
  logic [RowW-1:0]   row_buf_q [N];
  logic [RowW-1:0]   row_buf_d [N];
  logic              err_q, err_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [RowW-1:0]   wr_data_q, wr_data_d;
  logic [2:0]        wr_rows;
  logic [2:0]        wr_row;
  logic [RowW-1:0]   col_word;

`ifdef TRANS_ZERO_PAD_EN
  assign wr_rows = MaxSize;
`else
  assign wr_rows = size_q;
`endif

  always_comb begin
    row_buf_d = row_buf_q;
    if (cap_en_q) begin
      row_buf_d[cap_cnt_q] = mem_rd_data;
    end
  end

  // Built from row_buf_d so the first write can use the row captured on the same edge.
  always_comb begin
    col_word = '0;
    wr_row   = (state_q == StWrite) ? wr_cnt_q : 3'd0;
    for (int unsigned j = 0; j < N; j++) begin
      if (3'(j) < size_q && wr_row < size_q) begin
        col_word[(N-1-j)*ELEM_W +: ELEM_W] =
            row_buf_d[j][(N-1-32'(wr_row))*ELEM_W +: ELEM_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_cnt_d  = rd_cnt_q;
    cap_cnt_d = cap_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    cap_en_d  = rd_en_q;
    err_d     = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (size != 3'd0 && size <= MaxSize) begin
            state_d   = StRead;
            size_d    = size;
            src_d     = src_base;
            dst_d     = dst_base;
            rd_en_d   = 1'b1;
            rd_addr_d = src_base;
            rd_cnt_d  = 3'd1;
            cap_cnt_d = 3'd0;
            wr_cnt_d  = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (rd_cnt_q < size_q) begin
          rd_en_d   = 1'b1;
          rd_addr_d = src_q + ADDR_W'(rd_cnt_q);
          rd_cnt_d  = rd_cnt_q + 3'd1;
        end
        if (cap_en_q) begin
          cap_cnt_d = cap_cnt_q + 3'd1;
          if (cap_cnt_q == size_q - 3'd1) begin
            state_d   = StWrite;
            wr_en_d   = 1'b1;
            wr_addr_d = dst_q;
            wr_data_d = col_word;
            wr_cnt_d  = 3'd1;
          end
        end
      end
      StWrite: begin
        if (wr_cnt_q < wr_rows) begin
          wr_en_d   = 1'b1;
          wr_addr_d = dst_q + ADDR_W'(wr_cnt_q);
          wr_data_d = col_word;
          wr_cnt_d  = wr_cnt_q + 3'd1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      size_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rd_cnt_q  <= '0;
      cap_cnt_q <= '0;
      wr_cnt_q  <= '0;
      cap_en_q  <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < N; i++) begin
        row_buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_cnt_q  <= rd_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      cap_en_q  <= cap_en_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      row_buf_q <= row_buf_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign err         = err_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;

endmodule

// File: doc/trans_ctrl.md
# trans_ctrl

Sequencing controller for the coprocessor's matrix transpose. On `start` it reads a square matrix of up to N×N signed 8-bit elements, one packed row per word, from matrix memory into an internal N×N element buffer. It then writes the transposed matrix back, one packed row per word. The block sits between the instruction decoder (`start`/`done` handshake) and the matrix memory port. Because it reads the whole matrix before writing, it supports in-place transposition.

## Interface
- ELEM_W, 8, element width in bits
- N, 5, maximum matrix dimension; row word width is N*ELEM_W (40)
- ADDR_W, 4, matrix memory word-address width

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- size  in  3  matrix dimension, valid 1..N; latched with start
- src_base  in  ADDR_W  address of source row 0; latched with start
- dst_base  in  ADDR_W  address of destination row 0; latched with start
- busy  out  1  high from the first cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on a start with invalid size
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  N*ELEM_W  read data, returned exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  N*ELEM_W  write data

## Operation
- Lane packing: element j of a row occupies bits [(N-j)*ELEM_W-1 : (N-1-j)*ELEM_W], so lane 0 is the MSBs ([39:32]). Elements are signed and passed bit-exact, with no arithmetic.
- States: IDLE, READ, WRITE, DONE.
- IDLE → READ when start=1 and 1≤size≤N. Latch size, src_base and dst_base, and clear the row counter.
- IDLE with start=1 and an invalid size (0 or >N): pulse err for 1 cycle and stay in IDLE.
- READ: issue reads for rows k=0..size-1 at src_base+k. Capture mem_rd_data into buffer row k one cycle after each read. Go to WRITE on the cycle the last row is captured.
- WRITE: issue writes for rows r=0..W-1 at dst_base+r. Lane j of the write data is buf[j][r]; lanes with j≥size are zero. W is defined under Configuration. Go to DONE after the last write.
- DONE: assert done=1 and busy=1 for 1 cycle, then return to IDLE.
- start is ignored while busy. No request is queued.
- Address arithmetic is modulo 2^ADDR_W, so it wraps silently.
- src_base == dst_base is legal and gives a correct in-place transpose.
- Buffer lanes never captured in the current operation are never output.

## Timing
- Reset values: all outputs 0, state IDLE, buffer and counters cleared.
- A reset mid-operation aborts immediately. No mem_wr_en is asserted in the cycle after rst, and no done is produced.
- Take the start-accept edge as cycle 0:
  - mem_rd_en is high in cycles 1..size.
  - Captures occur in cycles 2..size+1.
  - mem_wr_en is high in cycles size+2..size+W+1.
  - done is high in cycle size+W+2.
- For size=5 without the macro, done occurs in cycle 12.
- mem_wr_en, mem_wr_addr and mem_wr_data are registered and change together.
- A start held high through DONE is re-accepted in the first IDLE cycle.

## Configuration
- TRANS_ZERO_PAD_EN defined: W=N. Rows r≥size are written as all zeros, so the full N×N destination region is overwritten.
- TRANS_ZERO_PAD_EN undefined: W=size. Rows at dst_base+size..N-1 are left untouched.

## Test plan
- size=5, src_base=0, dst_base=8, rows with element (i,j)=8'h(i)(j) (e.g. row0=40'h0001020304) → writes to addresses 8..12; row0 data 40'h0010203040; done in cycle 12.
- In-place: size=5, src=dst=3, elements signed with -1 on the diagonal and 8'h80 at (0,4) → memory holds the exact transpose; 8'h80 ends up at (4,0); no data is corrupted.
- size=3, src=14 (wraps to 14,15,0), row0=40'h0102030405 → write-data lanes 3–4 are 0. Row count written is 3 (done in cycle 8) without the macro, and 5 with rows 3–4 zero under TRANS_ZERO_PAD_EN.
- size=0, then size=6 with start → err pulses once for each; busy stays 0; no memory strobes.
- start pulsed again in cycle 4 of an operation → ignored; exactly one done.
- rst asserted in cycle 8 of a size=5 operation → in the next cycle all outputs are 0 and there are no further writes; a new start then completes normally.
